// File: rtl/data_mem_responder_if.sv
// M-stage data-memory bus: store strobe, byte address, store data, load data.
// master drives memwrite/addr/writedata; slave returns readdata.
interface data_mem_responder_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite, addr, writedata,
    input  readdata
  );

  modport slave (
    input  memwrite, addr, writedata,
    output readdata
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO timer/compare/IRQ, LED, switch input.
// Ports: clk, rst (async high), bus (slave), sw_i, led_o, irq_o, err_o.
module data_mem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_responder_if.slave bus,
  input  logic [LED_W-1:0] sw_i,
  output logic [LED_W-1:0] led_o,
  output logic             irq_o,
  output logic             err_o
);

  localparam logic [7:0] OFF_COUNT = 8'h00;
  localparam logic [7:0] OFF_CMP   = 8'h04;
  localparam logic [7:0] OFF_CTRL  = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h0C;
  localparam logic [7:0] OFF_LED   = 8'h10;
  localparam logic [7:0] OFF_SW    = 8'h14;
  localparam logic [7:0] OFF_EADDR = 8'h18;

  logic [31:0] mem [2**RAM_AW];

  logic [31:0]      count_q, count_d;
  logic [31:0]      cmp_q;
  logic             en_q, arl_q, ien_q;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic [LED_W-1:0] led_q;
  logic [31:0]      eaddr_q;
  logic [LED_W-1:0] sw1_q, sw2_q;

  logic       ram_hit, mmio_hit, fault, wr_ok;
  logic       ram_we, mmio_we, hit_now;
  logic [7:0] off;
  logic [31:0] wd;

  assign wd       = bus.writedata;
  assign off      = bus.addr[7:0];
  assign ram_hit  = (bus.addr[31:RAM_AW+2] == '0);
  assign mmio_hit = (bus.addr[31:16] == MMIO_BASE[31:16]);
  assign fault    = bus.memwrite &
                    ((bus.addr[1:0] != 2'b00) | ~(ram_hit | mmio_hit));
  assign wr_ok    = bus.memwrite & ~fault;
  assign ram_we   = wr_ok & ram_hit;
  assign mmio_we  = wr_ok & mmio_hit & ~ram_hit;
  assign hit_now  = en_q & (count_q == cmp_q);

  // Hardware set of a flag wins over a same-cycle W1C clear.
  always_comb begin
    match_d = match_q;
    err_d   = err_q;
    if (mmio_we && off == OFF_STAT) begin
      if (wd[0]) match_d = 1'b0;
      if (wd[1]) err_d   = 1'b0;
    end
    if (hit_now) match_d = 1'b1;
    if (fault)   err_d   = 1'b1;
  end

  // A CPU write to COUNT overrides increment/reload in that cycle.
  always_comb begin
    count_d = count_q;
    if (en_q) begin
      if (hit_now && arl_q) count_d = '0;
      else                  count_d = count_q + 32'd1;
    end
    if (mmio_we && off == OFF_COUNT) count_d = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      arl_q   <= 1'b0;
      ien_q   <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
      eaddr_q <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      err_q   <= err_d;
      sw1_q   <= sw_i;
      sw2_q   <= sw1_q;
      if (fault) eaddr_q <= bus.addr;
      if (mmio_we) begin
        unique case (1'b1)
          off == OFF_CMP:  cmp_q <= wd;
          off == OFF_CTRL: begin
            en_q  <= wd[0];
            arl_q <= wd[1];
            ien_q <= wd[2];
          end
          off == OFF_LED:  led_q <= wd[LED_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[bus.addr[RAM_AW+1:2]] <= wd;
  end

  always_comb begin
    bus.readdata = '0;
    if (ram_hit) begin
      bus.readdata = mem[bus.addr[RAM_AW+1:2]];
    end else if (mmio_hit) begin
      case (off)
        OFF_COUNT: bus.readdata = count_q;
        OFF_CMP:   bus.readdata = cmp_q;
        OFF_CTRL:  bus.readdata = {29'd0, ien_q, arl_q, en_q};
        OFF_STAT:  bus.readdata = {30'd0, err_q, match_q};
        OFF_LED:   bus.readdata = 32'(led_q);
        OFF_SW:    bus.readdata = 32'(sw2_q);
        OFF_EADDR: bus.readdata = eaddr_q;
        default:   bus.readdata = '0;
      endcase
    end
  end

  assign led_o = led_q;
  assign irq_o = match_q & ien_q;
  assign err_o = err_q;

endmodule
